// File: rtl/pattern_sequencer.sv
// Song-level sequencer: walks an order-list ROM and issues pattern loads to a note sequencer.
// Optional macro PATTERN_SEQUENCER_POSITION_EN adds o_position / o_row playback position outputs.
module pattern_sequencer #(
   parameter int ORDER_AW = 6
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_note_stb,
   input  logic                i_start,
   input  logic                i_stop,
   output logic [4:0]          o_new_addr,
   output logic [4:0]          o_new_pattern_len,
   output logic                o_new_addr_valid,
   output logic                o_playing,
   output logic                o_done,
   output logic [ORDER_AW-1:0] o_order_addr,
   input  logic [15:0]         i_order_data
`ifdef PATTERN_SEQUENCER_POSITION_EN
   ,
   output logic [ORDER_AW-1:0] o_position,
   output logic [5:0]          o_row
`endif
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_ARMED  = 3'd3,
      S_PLAY   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ORDER_AW-1:0] index_q, index_d;
   logic [5:0]          remain_q, remain_d;
   logic [5:0]          ticks_q, ticks_d;
   logic                marker_seen_q, marker_seen_d;
   logic [4:0]          addr_q, addr_d;
   logic [4:0]          len_q, len_d;
   logic                done_q, done_d;
   logic [5:0]          rom_ticks_s;
   logic                load_stb_s;

   assign rom_ticks_s = i_order_data[15:10];

   // Load request is qualified by reset and stop so nothing leaks in the cycle either is applied.
   assign load_stb_s = i_rst_n & ~i_stop & i_note_stb & (state_q == S_ARMED);

   // Next-state and datapath for the order-list walk.
   always_comb begin
      state_d       = state_q;
      index_d       = index_q;
      remain_d      = remain_q;
      ticks_d       = ticks_q;
      marker_seen_d = marker_seen_q;
      addr_d        = addr_q;
      len_d         = len_q;
      done_d        = 1'b0;
      if (i_stop) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  state_d       = S_FETCH;
                  index_d       = '0;
                  marker_seen_d = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_FETCH: begin
               state_d = S_DECODE;
            end
            S_DECODE: begin
               if (rom_ticks_s == 6'd0) begin
                  // Two markers in a row means the loop contains no playable entry.
                  if (marker_seen_q) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     index_d       = i_order_data[ORDER_AW-1:0];
                     marker_seen_d = 1'b1;
                     state_d       = S_FETCH;
                  end
               end else begin
                  addr_d        = i_order_data[4:0];
                  len_d         = i_order_data[9:5];
                  ticks_d       = rom_ticks_s;
                  index_d       = index_q + ORDER_AW'(1);
                  marker_seen_d = 1'b0;
                  state_d       = S_ARMED;
               end
            end
            S_ARMED: begin
               if (i_note_stb) begin
                  remain_d = ticks_q - 6'd1;
                  if (ticks_q == 6'd1) begin
                     state_d = S_FETCH;
                  end else begin
                     state_d = S_PLAY;
                  end
               end else begin
                  state_d = S_ARMED;
               end
            end
            S_PLAY: begin
               if (i_note_stb) begin
                  remain_d = remain_q - 6'd1;
                  if (remain_q == 6'd1) begin
                     state_d = S_FETCH;
                  end else begin
                     state_d = S_PLAY;
                  end
               end else begin
                  state_d = S_PLAY;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q       <= S_IDLE;
         index_q       <= '0;
         remain_q      <= 6'd0;
         ticks_q       <= 6'd0;
         marker_seen_q <= 1'b0;
         addr_q        <= 5'd0;
         len_q         <= 5'd0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         index_q       <= index_d;
         remain_q      <= remain_d;
         ticks_q       <= ticks_d;
         marker_seen_q <= marker_seen_d;
         addr_q        <= addr_d;
         len_q         <= len_d;
         done_q        <= done_d;
      end
   end

   assign o_new_addr        = addr_q;
   assign o_new_pattern_len = len_q;
   assign o_new_addr_valid  = load_stb_s;
   assign o_playing         = (state_q != S_IDLE);
   assign o_done            = done_q;
   assign o_order_addr      = index_q;

`ifdef PATTERN_SEQUENCER_POSITION_EN
   logic [ORDER_AW-1:0] cur_idx_q, cur_idx_d;
   logic [ORDER_AW-1:0] position_q, position_d;
   logic [5:0]          row_q, row_d;

   // Position tracking: entry index latched at decode, published on its load strobe.
   always_comb begin
      cur_idx_d  = cur_idx_q;
      position_d = position_q;
      row_d      = row_q;
      if ((state_q == S_DECODE) && (rom_ticks_s != 6'd0) && !i_stop) begin
         cur_idx_d = index_q;
      end else begin
         cur_idx_d = cur_idx_q;
      end
      if (load_stb_s) begin
         position_d = cur_idx_q;
         row_d      = 6'd0;
      end else if ((state_q == S_PLAY) && i_note_stb && !i_stop) begin
         row_d = row_q + 6'd1;
      end else begin
         row_d = row_q;
      end
   end

   // Position registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         cur_idx_q  <= '0;
         position_q <= '0;
         row_q      <= 6'd0;
      end else begin
         cur_idx_q  <= cur_idx_d;
         position_q <= position_d;
         row_q      <= row_d;
      end
   end

   assign o_position = position_q;
   assign o_row      = row_q;
`endif

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: table-driven strobe vectors plus hand-written corner sequences.
module tb_pattern_sequencer;

   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          note_stb = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic [4:0]    new_addr;
   logic [4:0]    new_len;
   logic          new_valid;
   logic          playing;
   logic          done;
   logic [AW-1:0] order_addr;
   logic [15:0]   order_data = 16'h0;
   logic [15:0]   rom [64];
`ifdef PATTERN_SEQUENCER_POSITION_EN
   logic [AW-1:0] position;
   logic [5:0]    row;
`endif

   int total = 0;
   int passed = 0;

   pattern_sequencer #(.ORDER_AW(AW)) dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_note_stb        (note_stb),
      .i_start           (start),
      .i_stop            (stop),
      .o_new_addr        (new_addr),
      .o_new_pattern_len (new_len),
      .o_new_addr_valid  (new_valid),
      .o_playing         (playing),
      .o_done            (done),
      .o_order_addr      (order_addr),
      .i_order_data      (order_data)
`ifdef PATTERN_SEQUENCER_POSITION_EN
      ,
      .o_position        (position),
      .o_row             (row)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous order ROM model.
   always @(posedge clk) order_data <= rom[order_addr];

   typedef struct packed {
      int         scen;
      logic       exp_valid;
      logic [4:0] exp_addr;
      logic [4:0] exp_len;
   } vec_t;

   vec_t vecs [17];

   function automatic logic [15:0] entry(input int ticks, input int len, input int addr);
      logic [5:0] t;
      logic [4:0] l;
      logic [4:0] a;
      t = 6'(ticks);
      l = 5'(len);
      a = 5'(addr);
      return {t, l, a};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      else passed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic load_rom(input int scen);
      for (int i = 0; i < 64; i++) rom[i] = 16'h0;
      case (scen)
         1: begin
            rom[0] = entry(3, 7, 4);
            rom[1] = 16'd0;
         end
         2: begin
            rom[0] = entry(1, 2, 0);
            rom[1] = entry(2, 3, 10);
            rom[2] = 16'd0;
         end
         3: begin
            rom[0]  = 16'd62;
            rom[62] = entry(1, 5, 2);
            rom[63] = entry(1, 6, 3);
         end
         4: begin
            rom[0] = 16'd1;
            rom[1] = 16'd0;
         end
         default: ;
      endcase
   endtask

   task automatic start_song();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
   endtask

   task automatic strobe_check(input string name, input logic exp_valid,
                               input logic [4:0] exp_addr, input logic [4:0] exp_len);
      note_stb = 1'b1;
      #1;
      check({name, "_valid"}, int'(new_valid), int'(exp_valid));
      if (exp_valid) begin
         check({name, "_addr"}, int'(new_addr), int'(exp_addr));
         check({name, "_len"}, int'(new_len), int'(exp_len));
      end
      @(posedge clk);
      #1;
      note_stb = 1'b0;
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_addr"}, int'(new_addr), 0);
      check({name, "_len"}, int'(new_len), 0);
      check({name, "_valid"}, int'(new_valid), 0);
      check({name, "_playing"}, int'(playing), 0);
      check({name, "_done"}, int'(done), 0);
      check({name, "_order_addr"}, int'(order_addr), 0);
   endtask

   initial begin
      int done_cnt;
      int first_done;
      int valid_seen;

      vecs[0]  = '{1, 1'b1, 5'd4, 5'd7};
      vecs[1]  = '{1, 1'b0, 5'd0, 5'd0};
      vecs[2]  = '{1, 1'b0, 5'd0, 5'd0};
      vecs[3]  = '{1, 1'b1, 5'd4, 5'd7};
      vecs[4]  = '{1, 1'b0, 5'd0, 5'd0};
      vecs[5]  = '{1, 1'b0, 5'd0, 5'd0};
      vecs[6]  = '{1, 1'b1, 5'd4, 5'd7};
      vecs[7]  = '{2, 1'b1, 5'd0, 5'd2};
      vecs[8]  = '{2, 1'b1, 5'd10, 5'd3};
      vecs[9]  = '{2, 1'b0, 5'd0, 5'd0};
      vecs[10] = '{2, 1'b1, 5'd0, 5'd2};
      vecs[11] = '{2, 1'b1, 5'd10, 5'd3};
      vecs[12] = '{2, 1'b0, 5'd0, 5'd0};
      vecs[13] = '{3, 1'b1, 5'd2, 5'd5};
      vecs[14] = '{3, 1'b1, 5'd3, 5'd6};
      vecs[15] = '{3, 1'b1, 5'd2, 5'd5};
      vecs[16] = '{3, 1'b1, 5'd3, 5'd6};

      load_rom(0);
      do_reset();
      check_reset_outputs("por");

      // Strobes are 8 clocks apart; a new scenario resets, reloads the ROM and starts.
      for (int i = 0; i < 17; i++) begin
         if (i == 0 || vecs[i].scen != vecs[(i == 0) ? 0 : i - 1].scen) begin
            do_reset();
            load_rom(vecs[i].scen);
            start_song();
            check($sformatf("vec%0d_playing", i), int'(playing), 1);
         end else begin
            repeat (7) tick();
         end
         strobe_check($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_addr, vecs[i].exp_len);
      end

      // Empty loop: back-to-back markers terminate the song.
      do_reset();
      load_rom(4);
      start = 1'b1;
      tick();
      start = 1'b0;
      done_cnt   = 0;
      first_done = -1;
      valid_seen = 0;
      for (int c = 0; c < 10; c++) begin
         if (done) begin
            done_cnt++;
            if (first_done < 0) first_done = c + 1;
         end
         note_stb = (c == 2);
         #1;
         if (new_valid) valid_seen++;
         tick();
         note_stb = 1'b0;
      end
      check("empty_done_count", done_cnt, 1);
      check("empty_done_within_6", int'(first_done >= 1 && first_done <= 6), 1);
      check("empty_no_valid", valid_seen, 0);
      check("empty_playing", int'(playing), 0);

      // Stop while playing with two strobes remaining.
      do_reset();
      load_rom(1);
      start_song();
      strobe_check("stop_load", 1'b1, 5'd4, 5'd7);
      repeat (3) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("stop_playing", int'(playing), 0);
      check("stop_addr_kept", int'(new_addr), 4);
      check("stop_len_kept", int'(new_len), 7);
      repeat (7) tick();
      strobe_check("stop_after1", 1'b0, 5'd0, 5'd0);
      repeat (7) tick();
      strobe_check("stop_after2", 1'b0, 5'd0, 5'd0);

      // Start and stop together: stop wins.
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      check("start_stop_playing", int'(playing), 0);

      // Start while playing is ignored: second entry must still follow.
      do_reset();
      load_rom(2);
      start_song();
      strobe_check("restart_first", 1'b1, 5'd0, 5'd2);
      repeat (4) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (2) tick();
      strobe_check("restart_ignored", 1'b1, 5'd10, 5'd3);

      // Reset while ARMED, coincident with a strobe.
      do_reset();
      load_rom(1);
      start_song();
      rst_n    = 1'b0;
      note_stb = 1'b1;
      #1;
      check("rst_stb_valid", int'(new_valid), 0);
      tick();
      rst_n    = 1'b1;
      note_stb = 1'b0;
      check_reset_outputs("mid_rst");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
